// File: rtl/mips_pkg.sv
// Shared EX-stage definitions: multiply sequencer state encoding, iteration count
// and the funct codes that ALU control decodes for multu/mfhi/mflo.
package mips_pkg;

    localparam int unsigned MUL_ITER = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } mul_state_t;

    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;

endpackage

// File: rtl/mul_seq_ctl_if.sv
// Request/result bundle between ALU control / hazard logic and the multiply sequencer.
interface mul_seq_ctl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 7
);
    logic             en_mul;
    logic             abort;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             hilo_rd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CNT_W-1:0] maxcount;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output en_mul, abort, op_a, op_b, hilo_rd,
        input  hi, lo, maxcount, busy, done, stall
    );

    modport slave (
        input  en_mul, abort, op_a, op_b, hilo_rd,
        output hi, lo, maxcount, busy, done, stall
    );
endinterface

// File: rtl/mul_seq_dp.sv
// Shift-add multiply datapath: multiplicand register plus the HI/LO pair, which
// shifts right one bit per step with the adder carry entering the top of HI.
module mul_seq_dp #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             clear,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   sum;

    // Partial-product add; the extra bit keeps the carry for the shift.
    always_comb begin
        sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (clear) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (load) begin
            mcand <= op_a;
            hi    <= '0;
            lo    <= op_b;
        end else if (step) begin
            {hi, lo} <= {sum, lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_seq_ctl.sv
// Multiply sequencer: FSM, iteration counter and pipeline stall for the multu
// resource; the arithmetic lives in mul_seq_dp.
module mul_seq_ctl
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_ITER,
    parameter int unsigned CNT_W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_seq_ctl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, step, clear;
    logic [WIDTH-1:0] hi_w, lo_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= CNT_MAX;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Abort outranks everything; en_mul during RUN is held off by the stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        clear   = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = CNT_MAX;
            clear   = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (bus.en_mul) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        load    = 1'b1;
                    end
                end
                RUN: begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_MAX;
                end
            endcase
        end
    end

    mul_seq_dp #(.WIDTH(WIDTH)) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .clear (clear),
        .op_a  (bus.op_a),
        .op_b  (bus.op_b),
        .hi    (hi_w),
        .lo    (lo_w)
    );

    assign bus.hi       = hi_w;
    assign bus.lo       = lo_w;
    assign bus.maxcount = cnt_q;
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.stall    = (state_q == RUN) & (bus.hilo_rd | bus.en_mul);

endmodule

// File: tb/tb_mul_seq_ctl.sv
// Directed bench for mul_seq_ctl: expected products are queued at issue time and
// a monitor compares them against hi/lo whenever done pulses.
module tb_mul_seq_ctl;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_q[$];

    mul_seq_ctl_if #(.WIDTH(32), .CNT_W(7)) bus ();

    mul_seq_ctl #(.WIDTH(32), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: every done pulse must match the oldest outstanding product.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("result_hi", 64'(bus.hi), 64'(e[63:32]));
                chk("result_lo", 64'(bus.lo), 64'(e[31:0]));
                chk("result_maxcount", 64'(bus.maxcount), 64'd32);
            end
        end
    end

    // Issue one start pulse; returns at the negedge after the start edge.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.en_mul = 1'b1;
        bus.op_a   = a;
        bus.op_b   = b;
        @(negedge clk);
        bus.en_mul = 1'b0;
    endtask

    // Counts busy cycles (sampled at negedges) until busy drops, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        bus.en_mul  = 1'b0;
        bus.abort   = 1'b0;
        bus.op_a    = '0;
        bus.op_b    = '0;
        bus.hilo_rd = 1'b0;
        rst_n       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_maxcount", 64'(bus.maxcount), 64'd32);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        rst_n = 1'b1;

        // 3 x 5: 32 busy cycles then done
        exp_q.push_back({32'h0, 32'd15});
        start(32'd3, 32'd5);
        chk("t1_maxcount_start", 64'(bus.maxcount), 64'd0);
        wait_idle(n);
        chk("t1_busy_cycles", 64'(n), 64'd32);
        chk("t1_done", 64'(bus.done), 64'd1);
        @(negedge clk);
        chk("t1_done_one_cycle", 64'(bus.done), 64'd0);

        // All-ones squared exercises carry retention
        exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("t2_busy_cycles", 64'(n), 64'd32);
        @(negedge clk);

        // mfhi/mflo at cycle 10 stalls until the product is ready
        exp_q.push_back({32'h0, 32'd42});
        start(32'd6, 32'd7);
        repeat (10) @(negedge clk);
        bus.hilo_rd = 1'b1;
        #1;
        chk("t3_stall_on", 64'(bus.stall), 64'd1);
        wait_idle(n);
        chk("t3_stall_cycles", 64'(n), 64'd22);
        chk("t3_stall_off", 64'(bus.stall), 64'd0);
        @(negedge clk);
        chk("t3_hold_hi", 64'(bus.hi), 64'd0);
        chk("t3_hold_lo", 64'(bus.lo), 64'd42);
        chk("t3_stall_idle", 64'(bus.stall), 64'd0);
        bus.hilo_rd = 1'b0;

        // Second multu arrives mid-flight; it is held, then starts from DONE
        exp_q.push_back({32'h0, 32'd63});
        start(32'd7, 32'd9);
        repeat (5) @(negedge clk);
        bus.en_mul = 1'b1;
        bus.op_a   = 32'd2;
        bus.op_b   = 32'd2;
        exp_q.push_back({32'h0, 32'd4});
        #1;
        chk("t4_stall", 64'(bus.stall), 64'd1);
        wait_idle(n);
        chk("t4_first_done", 64'(bus.done), 64'd1);
        @(negedge clk);
        bus.en_mul = 1'b0;
        chk("t4_restart_busy", 64'(bus.busy), 64'd1);
        chk("t4_restart_cnt", 64'(bus.maxcount), 64'd0);
        wait_idle(n);
        chk("t4_second_cycles", 64'(n), 64'd32);
        @(negedge clk);

        // Async reset at cycle 12 discards the partial product
        start(32'h1234, 32'h10);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_hi", 64'(bus.hi), 64'd0);
        chk("t5_rst_lo", 64'(bus.lo), 64'd0);
        chk("t5_rst_maxcount", 64'(bus.maxcount), 64'd32);
        chk("t5_rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort on the final iteration: no done pulse, HI/LO cleared
        start(32'd5, 32'd5);
        repeat (31) @(negedge clk);
        chk("t5_abort_precnt", 64'(bus.maxcount), 64'd31);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("t5_abort_busy", 64'(bus.busy), 64'd0);
        chk("t5_abort_done", 64'(bus.done), 64'd0);
        chk("t5_abort_hi", 64'(bus.hi), 64'd0);
        chk("t5_abort_lo", 64'(bus.lo), 64'd0);
        chk("t5_abort_maxcount", 64'(bus.maxcount), 64'd32);
        repeat (3) @(negedge clk);

        // Back-to-back: en_mul held across DONE restarts without an IDLE cycle
        exp_q.push_back({32'h1, 32'h0});
        exp_q.push_back({32'h1, 32'h0});
        @(negedge clk);
        bus.en_mul = 1'b1;
        bus.op_a   = 32'h0001_0000;
        bus.op_b   = 32'h0001_0000;
        @(negedge clk);
        wait_idle(n);
        chk("t6_first_cycles", 64'(n), 64'd32);
        chk("t6_first_done", 64'(bus.done), 64'd1);
        @(negedge clk);
        bus.en_mul = 1'b0;
        chk("t6_restart_busy", 64'(bus.busy), 64'd1);
        chk("t6_restart_cnt", 64'(bus.maxcount), 64'd0);
        wait_idle(n);
        chk("t6_second_cycles", 64'(n), 64'd32);
        repeat (3) @(negedge clk);
        chk("t6_idle_maxcount", 64'(bus.maxcount), 64'd32);

        chk("outstanding_results", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctl.md
Name: mul_seq_ctl

Overview:
Sequencing controller for the unsigned multiply (multu) resource in the EX stage. It accepts the en_mul request produced by ALU control and runs a 32-iteration shift-add multiply into the HI/LO registers. It reports progress as maxcount back to ALU control. It stalls the pipeline when mfhi/mflo or another multu arrives while a multiply is in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH bits each
CNT_W, 7, iteration counter width; must hold the value WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en_mul  input  1  start request from ALU control (multu, not nop)
abort  input  1  synchronous pipeline flush; kills an in-flight multiply
op_a  input  WIDTH  multiplicand (rs)
op_b  input  WIDTH  multiplier (rt)
hilo_rd  input  1  EX holds mfhi or mflo
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
maxcount  output  CNT_W  iteration count; WIDTH means idle/complete
busy  output  1  multiply in progress
done  output  1  one-cycle pulse: product valid
stall  output  1  freeze IF/ID/EX this cycle

Behaviour:
- Reset (rst_n=0, async): state=IDLE, hi=0, lo=0, mcand=0, maxcount=WIDTH, busy=0, done=0, stall=0. Reset mid-RUN discards the partial product.
- FSM states: IDLE, RUN, DONE. Registered state; outputs decoded from state and registers.
- IDLE, en_mul=1 at a clock edge: mcand<=op_a, lo<=op_b, hi<=0, maxcount<=0, go to RUN.
- RUN, each edge:
  - sum[WIDTH:0] = {1'b0,hi} + (lo[0] ? mcand : 0)
  - {hi,lo} <= {sum, lo[WIDTH-1:1]}, a 65-bit shift right by 1 keeping the carry
  - maxcount <= maxcount+1
  - when maxcount==WIDTH-1 the next state is DONE (maxcount becomes WIDTH)
- Latency: start sampled at edge 0. Iterations run on edges 1..32. DONE is entered at edge 32, so done=1 in the cycle after edge 32.
- DONE: done=1 for exactly one cycle.
  - en_mul=1 restarts exactly as from IDLE.
  - Otherwise go to IDLE. hi/lo hold.
- busy = (state==RUN). hi/lo are architecturally valid only when busy=0.
- stall = busy & (hilo_rd | en_mul). The stall is combinational, so the requester is held until the result is ready.
- en_mul in RUN: ignored by the FSM; the stall holds the instruction. It is accepted in DONE or IDLE after release.
- abort has priority over en_mul in every state.
  - Any state: go to IDLE, maxcount<=WIDTH, hi/lo<=0, done=0.
  - abort in the same cycle as the final iteration: abort wins and done is not asserted.
- hilo_rd in IDLE/DONE: no stall; hi/lo are read directly.
- Arithmetic is strictly unsigned; the carry out of the top bit is kept in the shift, and no overflow is possible.
- maxcount saturates at WIDTH outside RUN. It never wraps.

Decomposition:
- Shared package mips_pkg:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - MUL_ITER=32
  - Funct constants F_MULTU=6'd25, F_MFHI=6'd16, F_MFLO=6'd18, shared with ALU control
- One natural sub-module, mul_seq_dp: holds the mcand/hi/lo registers, the adder and the shifter.
  - Controls: load, step, clear.
  - mul_seq_ctl keeps the FSM, counter and stall logic.

Test Plan:
- Reset then op_a=3, op_b=5, en_mul pulse: busy=1 for 32 cycles; done pulse 32 cycles after the start edge; hi=0, lo=15, maxcount=32.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001 (checks carry retention).
- Start multiply; at cycle 10 assert hilo_rd: stall=1 from cycle 10 until busy falls. Then stall=0 and hi/lo hold the final product.
- Start 7×9; at cycle 5 assert en_mul with op_a=2, op_b=2: stall=1, first product unaffected (lo=63). The second multiply starts on the DONE cycle and yields lo=4.
- Start multiply; drop rst_n at cycle 12: immediate hi=lo=0, maxcount=32, busy=0. Likewise abort at cycle 31 (final iteration): IDLE, no done pulse, hi=lo=0.
- Back-to-back: en_mul held high across DONE with op_a=0x10000, op_b=0x10000: restart with no IDLE cycle; result hi=1, lo=0.
